// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: per-stage register-file hazard info coming in from the
// pipeline, stall/flush/freeze and forwarding controls going back out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rs1_addr;
  logic [4:0]       ex_rs2_addr;
  logic             ex_reg_write_enable;
  logic [4:0]       ex_reg_write_addr;
  logic             ex_is_load;
  logic             mem_reg_write_enable;
  logic [4:0]       mem_reg_write_addr;
  logic             wb_reg_write_enable;
  logic [4:0]       wb_reg_write_addr;
  logic             branch_taken;
  logic             dmem_busy;
  logic             stall_flag;
  logic             branch_flag;
  logic             freeze;
  logic [1:0]       fwd_sel_1;
  logic [1:0]       fwd_sel_2;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: supplies stage info, consumes controls.
  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rs1_addr, ex_rs2_addr, ex_reg_write_enable, ex_reg_write_addr, ex_is_load,
           mem_reg_write_enable, mem_reg_write_addr, wb_reg_write_enable, wb_reg_write_addr,
           branch_taken, dmem_busy,
    input  stall_flag, branch_flag, freeze, fwd_sel_1, fwd_sel_2, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           ex_rs1_addr, ex_rs2_addr, ex_reg_write_enable, ex_reg_write_addr, ex_is_load,
           mem_reg_write_enable, mem_reg_write_addr, wb_reg_write_enable, wb_reg_write_addr,
           branch_taken, dmem_busy,
    output stall_flag, branch_flag, freeze, fwd_sel_1, fwd_sel_2, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory
// freeze, EX operand forwarding and saturating stall/flush counters.
// All controls are combinational from state + inputs so they act this cycle.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic             pending, pending_nxt;
  logic             load_use, branch;
  logic             stall_flag, branch_flag, freeze;
  logic [1:0]       fwd_sel_1, fwd_sel_2;
  logic [CNT_W-1:0] stall_count, flush_count;

  // Forward source for one EX operand; MEM result is newer, so it wins over WB.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs,
                                          input logic mem_we, input logic [4:0] mem_wa,
                                          input logic wb_we,  input logic [4:0] wb_wa);
    if (mem_we && mem_wa != 5'd0 && mem_wa == rs)   fwd_pick = 2'd1;
    else if (wb_we && wb_wa != 5'd0 && wb_wa == rs) fwd_pick = 2'd2;
    else                                            fwd_pick = 2'd0;
  endfunction

  // Hazard detection terms.
  always_comb begin
    load_use = bus.ex_is_load && bus.ex_reg_write_enable && bus.ex_reg_write_addr != 5'd0 &&
               ((bus.id_rs1_used && bus.id_rs1_addr == bus.ex_reg_write_addr) ||
                (bus.id_rs2_used && bus.id_rs2_addr == bus.ex_reg_write_addr));
    branch   = bus.branch_taken || pending;
  end

  // Control decode and next state; priority is memory wait, then branch, then load-use.
  always_comb begin
    stall_flag  = 1'b0;
    branch_flag = 1'b0;
    freeze      = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    if (!rst) begin
      case (state)
        RUN, LOAD_STALL: begin
          if (bus.dmem_busy) begin
            // A branch resolving while frozen must not be lost; replay it later.
            freeze      = 1'b1;
            pending_nxt = pending || bus.branch_taken;
            state_nxt   = MEM_WAIT;
          end else if (branch) begin
            branch_flag = 1'b1;
            pending_nxt = 1'b0;
            state_nxt   = RUN;
          end else if (load_use && state == RUN) begin
            // The bubble already separates load and consumer, so LOAD_STALL ignores load_use.
            stall_flag  = 1'b1;
            state_nxt   = LOAD_STALL;
          end else begin
            state_nxt   = RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_busy) begin
            freeze      = 1'b1;
            pending_nxt = pending || bus.branch_taken;
          end else begin
            state_nxt = RUN;
            if (branch) begin
              branch_flag = 1'b1;
              pending_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Operand forwarding, held at regfile during reset.
  always_comb begin
    fwd_sel_1 = 2'd0;
    fwd_sel_2 = 2'd0;
    if (!rst) begin
      fwd_sel_1 = fwd_pick(bus.ex_rs1_addr, bus.mem_reg_write_enable, bus.mem_reg_write_addr,
                           bus.wb_reg_write_enable, bus.wb_reg_write_addr);
      fwd_sel_2 = fwd_pick(bus.ex_rs2_addr, bus.mem_reg_write_enable, bus.mem_reg_write_addr,
                           bus.wb_reg_write_enable, bus.wb_reg_write_addr);
    end
  end

  // FSM state and pending-branch bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((stall_flag || freeze) && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (branch_flag && flush_count != '1)            flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.stall_flag  = stall_flag;
  assign bus.branch_flag = branch_flag;
  assign bus.freeze      = freeze;
  assign bus.fwd_sel_1   = fwd_sel_1;
  assign bus.fwd_sel_2   = fwd_sel_2;
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios, expectations queued per cycle
// and popped/compared at the falling edge. Counters use a 4-bit width so
// saturation is reachable quickly.
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int W  = 7 + 2 * CW;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [CW-1:0] e_scnt, e_fcnt;
  logic [W-1:0]  sb[$];
  logic [W-1:0]  exp_v;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();
  hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] got();
    got = {bus.stall_flag, bus.branch_flag, bus.freeze, bus.fwd_sel_1, bus.fwd_sel_2,
           bus.stall_count, bus.flush_count};
  endfunction

  // Expected outputs for the current cycle; then advances the counter
  // expectation to what the next cycle should show.
  function automatic logic [W-1:0] mk(input logic s, input logic b, input logic f,
                                      input logic [1:0] f1, input logic [1:0] f2);
    mk = {s, b, f, f1, f2, e_scnt, e_fcnt};
    if ((s | f) && e_scnt != {CW{1'b1}}) e_scnt = e_scnt + 1'b1;
    if (b && e_fcnt != {CW{1'b1}})       e_fcnt = e_fcnt + 1'b1;
  endfunction

  task automatic idle();
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.ex_rs1_addr = 0; bus.ex_rs2_addr = 0;
    bus.ex_reg_write_enable = 0; bus.ex_reg_write_addr = 0; bus.ex_is_load = 0;
    bus.mem_reg_write_enable = 0; bus.mem_reg_write_addr = 0;
    bus.wb_reg_write_enable = 0; bus.wb_reg_write_addr = 0;
    bus.branch_taken = 0; bus.dmem_busy = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic set_load(input logic [4:0] wa, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    bus.ex_is_load = 1; bus.ex_reg_write_enable = 1; bus.ex_reg_write_addr = wa;
    bus.id_rs1_addr = rs1; bus.id_rs1_used = u1; bus.id_rs2_addr = rs2; bus.id_rs2_used = u2;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.dmem_busy = 1; bus.branch_taken = 1;
    bus.ex_rs1_addr = 7; bus.mem_reg_write_enable = 1; bus.mem_reg_write_addr = 7;
    set_load(5, 5, 1, 0, 0);
    #12;
    total++;
    if (got() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", got(), {W{1'b0}});
    end
    idle();
    e_scnt = '0; e_fcnt = '0;
    @(negedge clk); rst = 1'b0;
    next();
  endtask

  task automatic test_load_use();
    // x5 load, ID reads x5 on rs1: one stall cycle then none
    set_load(5, 5, 1, 0, 0);
    sb.push_back(mk(1, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_use_stall got=%h want=%h", got(), exp_v); end
    next();
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_stall_one_cycle got=%h want=%h", got(), exp_v); end
    next(); idle();
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v || bus.stall_count !== 4'd1) begin
      bad++; $display("FAIL load_use_count got=%h want=%h", got(), exp_v);
    end
    // destination x0 never stalls
    next(); set_load(0, 0, 1, 0, 1);
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_use_x0 got=%h want=%h", got(), exp_v); end
    // rs2 matches but is not read
    next(); set_load(5, 3, 1, 5, 0);
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_use_rs2_unused got=%h want=%h", got(), exp_v); end
    // rs2 matches and is read
    next(); set_load(5, 3, 1, 5, 1);
    sb.push_back(mk(1, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_use_rs2 got=%h want=%h", got(), exp_v); end
    next(); idle();
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL load_use_rs2_after got=%h want=%h", got(), exp_v); end
    next();
  endtask

  task automatic test_back_to_back();
    // hazard held across three cycles: stall, bubble, stall again
    set_load(9, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(i != 1, 0, 0, 0, 0));
      @(negedge clk); exp_v = sb.pop_front(); total++;
      if (got() !== exp_v) begin bad++; $display("FAIL back_to_back_%0d got=%h want=%h", i, got(), exp_v); end
      next();
    end
    idle();
    next(); // LOAD_STALL cycle after the last stall; nothing pending
  endtask

  task automatic test_mem_wait();
    // busy 3 cycles, branch in cycle 2: freeze x3 then branch_flag
    for (int i = 0; i < 5; i++) begin
      bus.dmem_busy    = (i < 3);
      bus.branch_taken = (i == 1);
      sb.push_back(mk(0, i == 3, i < 3, 0, 0));
      @(negedge clk); exp_v = sb.pop_front(); total++;
      if (got() !== exp_v) begin bad++; $display("FAIL mem_wait_%0d got=%h want=%h", i, got(), exp_v); end
      next();
    end
    idle();
  endtask

  task automatic test_priority();
    // branch beats load-use in the same cycle
    set_load(5, 5, 1, 0, 0); bus.branch_taken = 1;
    sb.push_back(mk(0, 1, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL branch_over_load got=%h want=%h", got(), exp_v); end
    next(); idle();
    // busy beats branch; branch replays after the freeze
    bus.dmem_busy = 1; bus.branch_taken = 1;
    set_load(5, 5, 1, 0, 0);
    sb.push_back(mk(0, 0, 1, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL busy_over_branch got=%h want=%h", got(), exp_v); end
    next(); idle();
    sb.push_back(mk(0, 1, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL pending_replay got=%h want=%h", got(), exp_v); end
    next();
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL pending_cleared got=%h want=%h", got(), exp_v); end
    next();
  endtask

  task automatic test_forward();
    // rs1, rs2, mem_we, mem_wa, wb_we, wb_wa, fwd1, fwd2
    logic [4:0] t_rs1[4] = '{5'd7, 5'd7, 5'd0, 5'd7};
    logic [4:0] t_rs2[4] = '{5'd7, 5'd3, 5'd0, 5'd3};
    logic       t_mwe[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] t_mwa[4] = '{5'd7, 5'd7, 5'd0, 5'd3};
    logic       t_wwe[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] t_wwa[4] = '{5'd7, 5'd7, 5'd0, 5'd7};
    logic [1:0] t_f1[4]  = '{2'd1, 2'd2, 2'd0, 2'd2};
    logic [1:0] t_f2[4]  = '{2'd1, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      bus.ex_rs1_addr = t_rs1[i]; bus.ex_rs2_addr = t_rs2[i];
      bus.mem_reg_write_enable = t_mwe[i]; bus.mem_reg_write_addr = t_mwa[i];
      bus.wb_reg_write_enable = t_wwe[i]; bus.wb_reg_write_addr = t_wwa[i];
      sb.push_back(mk(0, 0, 0, t_f1[i], t_f2[i]));
      @(negedge clk); exp_v = sb.pop_front(); total++;
      if (got() !== exp_v) begin bad++; $display("FAIL forward_%0d got=%h want=%h", i, got(), exp_v); end
      next();
    end
    idle();
  endtask

  task automatic test_saturate_and_reset();
    bus.dmem_busy = 1;
    for (int i = 0; i < 20; i++) begin
      sb.push_back(mk(0, 0, 1, 0, 0));
      @(negedge clk); exp_v = sb.pop_front(); total++;
      if (got() !== exp_v) begin bad++; $display("FAIL saturate_%0d got=%h want=%h", i, got(), exp_v); end
      next();
    end
    total++;
    if (bus.stall_count !== 4'hF) begin
      bad++; $display("FAIL stall_count_sat got=%0d want=15", bus.stall_count);
    end
    // leave a branch pending inside MEM_WAIT, then reset mid-cycle
    bus.branch_taken = 1;
    next(); bus.branch_taken = 0;
    sb.push_back(mk(0, 0, 1, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL pre_reset_freeze got=%h want=%h", got(), exp_v); end
    #2 rst = 1'b1;
    #1 total++;
    if (got() !== '0) begin bad++; $display("FAIL reset_mid_wait got=%h want=%h", got(), {W{1'b0}}); end
    e_scnt = '0; e_fcnt = '0;
    idle();
    @(negedge clk); rst = 1'b0;
    next();
    // no freeze and no stale branch after reset
    sb.push_back(mk(0, 0, 0, 0, 0));
    @(negedge clk); exp_v = sb.pop_front(); total++;
    if (got() !== exp_v) begin bad++; $display("FAIL post_reset_run got=%h want=%h", got(), exp_v); end
    next();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_mem_wait();
    test_priority();
    test_forward();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the saturating performance counters.
REQ-002 SHALL have port clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads that source.
REQ-006 SHALL have ports ex_rs1_addr, ex_rs2_addr  in  5 each  source registers of the instruction in EX.
REQ-007 SHALL have ports ex_reg_write_enable in 1, ex_reg_write_addr in 5, ex_is_load in 1  EX-stage destination info.
REQ-008 SHALL have ports mem_reg_write_enable in 1, mem_reg_write_addr in 5  MEM-stage destination info.
REQ-009 SHALL have ports wb_reg_write_enable in 1, wb_reg_write_addr in 5  WB-stage destination info.
REQ-010 SHALL have port branch_taken  in  1  MEM stage resolved a taken branch this cycle.
REQ-011 SHALL have port dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
REQ-012 SHALL have outputs stall_flag 1, branch_flag 1, freeze 1  per-stage pipeline-register controls.
REQ-013 SHALL have outputs fwd_sel_1, fwd_sel_2  2 each  EX operand source: 0 regfile, 1 MEM-stage ALU result, 2 WB-stage write data.
REQ-014 SHALL have outputs stall_count, flush_count  CNT_W each  performance counters.

Function
REQ-015 SHALL implement FSM states RUN, LOAD_STALL, MEM_WAIT.
REQ-016 SHALL define load_use = ex_is_load & ex_reg_write_enable & ex_reg_write_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_reg_write_addr) | (id_rs2_used & id_rs2_addr==ex_reg_write_addr)).
REQ-017 SHALL give event priority dmem_busy > branch (branch_taken or pending) > load_use.
REQ-018 RUN: dmem_busy -> freeze=1, next MEM_WAIT; else branch -> branch_flag=1 same cycle, stay RUN; else load_use -> stall_flag=1 same cycle, next LOAD_STALL; else all flags 0.
REQ-019 LOAD_STALL: lasts exactly one cycle; stall_flag=0, load_use ignored; dmem_busy/branch handled as in RUN; otherwise next RUN.
REQ-020 MEM_WAIT: freeze=1, stall_flag=0, branch_flag=0 while dmem_busy=1; on first cycle dmem_busy=0, freeze=0 and next RUN.
REQ-021 SHALL latch branch_taken seen while freeze=1 into a pending bit; pending bit drives branch_flag on the first non-frozen cycle, then clears.
REQ-022 stall_flag, branch_flag, freeze SHALL be mutually exclusive (at most one high per cycle).
REQ-023 fwd_sel_n SHALL be 1 when mem_reg_write_enable & mem_reg_write_addr!=0 & match ex_rsn_addr; else 2 when the WB equivalent matches; else 0; MEM beats WB on double match.
REQ-024 fwd_sel_n SHALL never select a source for address x0.
REQ-025 stall_count SHALL increment by 1 each cycle stall_flag|freeze is high, saturating at all-ones.
REQ-026 flush_count SHALL increment by 1 each cycle branch_flag is high, saturating at all-ones.
REQ-027 Flags and fwd_sel SHALL be combinational from state, pending bit and inputs; no extra latency.

Reset
REQ-028 rst=1 SHALL immediately force state RUN, pending bit 0, stall_count 0, flush_count 0.
REQ-029 During rst=1, stall_flag, branch_flag, freeze SHALL be 0 and fwd_sel_1/2 SHALL be 0.
REQ-030 Reset asserted mid-MEM_WAIT or with branch pending SHALL discard the wait/pending; first post-reset cycle behaves as RUN.

Verification
REQ-031 Load x5 in EX, ID reads x5 (rs1_used=1) -> stall_flag=1 one cycle, next cycle 0, stall_count=1.
REQ-032 Load-use with dest x0 -> stall_flag stays 0; load-use with id_rs2_used=0 on rs2 match -> no stall.
REQ-033 dmem_busy high 3 cycles, branch_taken pulsed in 2nd -> freeze=1 for 3 cycles, branch_flag=1 on 4th, flush_count=1, stall_count=3.
REQ-034 branch_taken and load_use same cycle -> branch_flag=1, stall_flag=0.
REQ-035 ex_rs1=x7, MEM and WB both write x7 -> fwd_sel_1=1; MEM writes x0, ex_rs1=x0 -> fwd_sel_1=0.
REQ-036 CNT_W=4, 20 stall cycles -> stall_count holds 15; rst mid-MEM_WAIT -> freeze=0 immediately, counters 0.
